// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter in front of a single-ported memory.
// Alternating priority on ties, fetch kill on flush, and a per-access timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  state_t          state;
  logic            last_grant_d;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;
  logic            lat_we;
  logic [CW-1:0]   wait_cnt;
  logic            kill;
  logic [31:0]     err_addr_q;

  logic            if_valid;
  logic            grant_d;
  logic            grant_if;
  logic            busy;
  logic            timed_out;
  logic            done;
  logic            if_hit;
  logic            d_hit;

  // A same-cycle flush invalidates the fetch request, and on ties the
  // requester not granted last wins.
  assign if_valid  = if_req & ~if_flush;
  assign grant_d   = d_req & (~if_valid | ~last_grant_d);
  assign grant_if  = if_valid & ~grant_d;
  assign busy      = (state != IDLE);
  assign timed_out = busy & ~mem_ready & (wait_cnt == CW'(TIMEOUT));
  assign done      = busy & (mem_ready | timed_out);
  assign if_hit    = ~rst & (state == IF_BUSY) & done & ~kill & ~if_flush;
  assign d_hit     = ~rst & (state == D_BUSY) & done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      lat_we       <= 1'b0;
      wait_cnt     <= '0;
      kill         <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          kill     <= 1'b0;
          if (grant_d) begin
            state        <= D_BUSY;
            last_grant_d <= 1'b1;
            lat_addr     <= d_addr;
            lat_wdata    <= d_wdata;
            lat_be       <= d_be;
            lat_we       <= d_we;
          end else if (grant_if) begin
            state        <= IF_BUSY;
            last_grant_d <= 1'b0;
            lat_addr     <= if_addr;
            lat_wdata    <= '0;
            lat_be       <= 4'hF;
            lat_we       <= 1'b0;
          end
        end
        IF_BUSY, D_BUSY: begin
          if (done) begin
            state <= IDLE;
            kill  <= 1'b0;
            if (timed_out) err_addr_q <= lat_addr;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if (state == IF_BUSY && if_flush) kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pulses follow mem_ready combinationally; everything is
  // forced low while reset is held.
  assign if_ready  = if_hit;
  assign if_rdata  = if_hit ? (mem_ready ? mem_rdata : NOP) : 32'h0;
  assign d_ready   = d_hit;
  assign d_rdata   = (d_hit & mem_ready) ? mem_rdata : 32'h0;
  assign bus_err   = ~rst & timed_out;
  assign err_addr  = rst ? 32'h0 : err_addr_q;

  assign mem_req   = ~rst & busy;
  assign mem_addr  = mem_req ? lat_addr  : 32'h0;
  assign mem_wdata = mem_req ? lat_wdata : 32'h0;
  assign mem_be    = mem_req ? lat_be    : 4'h0;
  assign mem_we    = mem_req & lat_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): arbitration, flush, timeout, reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        bus_err;
  logic [31:0] err_addr;

  int unsigned total  = 0;
  int unsigned passed = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mem_req"},  32'(mem_req),  32'h0);
    chk({tag, ".mem_addr"}, mem_addr,      32'h0);
    chk({tag, ".if_ready"}, 32'(if_ready), 32'h0);
    chk({tag, ".d_ready"},  32'(d_ready),  32'h0);
    chk({tag, ".bus_err"},  32'(bus_err),  32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_ready = 0; mem_rdata = 0;
    nxt(); nxt();
    if_req = 1; d_req = 1; mem_ready = 1;
    smp(); chk_quiet("reset");
    chk("reset.err_addr", err_addr, 32'h0);

    // Tie from reset: data, idle, fetch, idle, data
    nxt(); rst = 0; if_addr = 32'h400; d_addr = 32'h2000; d_be = 4'hF;
    mem_rdata = 32'hAAAA_0001;
    smp(); chk("tie0.mem_req", 32'(mem_req), 32'h0);
    nxt(); smp();
    chk("tie1.mem_addr", mem_addr, 32'h2000);
    chk("tie1.d_ready", 32'(d_ready), 32'h1);
    chk("tie1.d_rdata", d_rdata, 32'hAAAA_0001);
    chk("tie1.if_ready", 32'(if_ready), 32'h0);
    nxt(); smp(); chk("tie2.mem_req", 32'(mem_req), 32'h0);
    nxt(); smp();
    chk("tie3.mem_addr", mem_addr, 32'h400);
    chk("tie3.if_ready", 32'(if_ready), 32'h1);
    chk("tie3.d_ready", 32'(d_ready), 32'h0);
    chk("tie3.mem_be", 32'(mem_be), 32'hF);
    nxt(); smp(); chk("tie4.mem_req", 32'(mem_req), 32'h0);
    nxt(); smp(); chk("tie5.mem_addr", mem_addr, 32'h2000);

    // Single fetch, answered immediately
    nxt(); d_req = 0; if_addr = 32'h100; mem_rdata = 32'h0050_0093;
    smp(); chk("fetch0.mem_req", 32'(mem_req), 32'h0);
    nxt(); smp();
    chk("fetch1.mem_req", 32'(mem_req), 32'h1);
    chk("fetch1.mem_addr", mem_addr, 32'h100);
    chk("fetch1.mem_we", 32'(mem_we), 32'h0);
    chk("fetch1.if_ready", 32'(if_ready), 32'h1);
    chk("fetch1.if_rdata", if_rdata, 32'h0050_0093);
    nxt(); if_req = 0;
    smp(); chk("fetch2.mem_req", 32'(mem_req), 32'h0);
    chk("fetch2.if_rdata", if_rdata, 32'h0);

    // Store with one wait state
    nxt(); d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h2004;
    d_wdata = 32'hDEAD_BEEF; mem_ready = 0;
    nxt(); smp();
    chk("store.mem_we", 32'(mem_we), 32'h1);
    chk("store.mem_be", 32'(mem_be), 32'h3);
    chk("store.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("store.wait_d_ready", 32'(d_ready), 32'h0);
    nxt(); mem_ready = 1; smp();
    chk("store.d_ready", 32'(d_ready), 32'h1);
    nxt(); d_req = 0; d_we = 0; mem_ready = 0;
    smp(); chk("store.after_d_ready", 32'(d_ready), 32'h0);
    chk("store.after_mem_req", 32'(mem_req), 32'h0);

    // Same-cycle flush in IDLE blocks the grant
    nxt(); if_req = 1; if_flush = 1; if_addr = 32'h1F0;
    nxt(); if_req = 0; if_flush = 0;
    smp(); chk("sameflush.mem_req", 32'(mem_req), 32'h0);

    // Flush during IF_BUSY, then a fresh fetch
    nxt(); if_req = 1; if_addr = 32'h200;
    nxt(); if_req = 0; if_flush = 1;
    smp(); chk("flush1.mem_req", 32'(mem_req), 32'h1);
    nxt(); if_flush = 0;
    nxt(); mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    smp(); chk("flush3.if_ready", 32'(if_ready), 32'h0);
    chk("flush3.if_rdata", if_rdata, 32'h0);
    nxt(); if_req = 1; if_addr = 32'h300; mem_rdata = 32'h1234_5678;
    smp(); chk("flush4.mem_req", 32'(mem_req), 32'h0);
    nxt(); smp();
    chk("refetch.mem_addr", mem_addr, 32'h300);
    chk("refetch.if_ready", 32'(if_ready), 32'h1);
    chk("refetch.if_rdata", if_rdata, 32'h1234_5678);

    // Load timeout: four silent BUSY cycles, abort on the fifth
    nxt(); if_req = 0; d_req = 1; d_addr = 32'h3000; mem_ready = 0;
    mem_rdata = 32'h0000_0BAD;
    for (int i = 1; i <= 4; i++) begin
      nxt(); smp();
      chk($sformatf("tmo_wait%0d.d_ready", i), 32'(d_ready), 32'h0);
      chk($sformatf("tmo_wait%0d.bus_err", i), 32'(bus_err), 32'h0);
    end
    nxt(); smp();
    chk("tmo.d_ready", 32'(d_ready), 32'h1);
    chk("tmo.d_rdata", d_rdata, 32'h0);
    chk("tmo.bus_err", 32'(bus_err), 32'h1);
    nxt(); d_req = 0;
    smp(); chk("tmo.err_addr", err_addr, 32'h3000);
    chk("tmo.bus_err_clear", 32'(bus_err), 32'h0);

    // mem_ready on the timeout cycle is a normal completion
    nxt(); if_req = 1; if_addr = 32'h500;
    for (int i = 1; i <= 4; i++) nxt();
    nxt(); mem_ready = 1; mem_rdata = 32'h1111_1111;
    smp(); chk("tmo_ok.if_ready", 32'(if_ready), 32'h1);
    chk("tmo_ok.if_rdata", if_rdata, 32'h1111_1111);
    chk("tmo_ok.bus_err", 32'(bus_err), 32'h0);

    // Fetch timeout returns NOP
    nxt(); if_addr = 32'h600; mem_ready = 0;
    for (int i = 1; i <= 5; i++) nxt();
    smp(); chk("tmo_if.if_ready", 32'(if_ready), 32'h1);
    chk("tmo_if.if_rdata", if_rdata, 32'h0000_0013);
    chk("tmo_if.bus_err", 32'(bus_err), 32'h1);
    nxt(); if_req = 0;
    smp(); chk("tmo_if.err_addr", err_addr, 32'h600);

    // Reset during D_BUSY abandons the access
    nxt(); d_req = 1; d_addr = 32'h4000;
    nxt(); rst = 1; mem_ready = 1; mem_rdata = 32'h5555_5555;
    smp(); chk_quiet("rst_busy");
    chk("rst_busy.d_rdata", d_rdata, 32'h0);
    nxt(); rst = 0; d_req = 0; if_req = 1; if_addr = 32'h700;
    mem_rdata = 32'h0000_ABCD;
    smp(); chk_quiet("rst_after");
    chk("rst_after.err_addr", err_addr, 32'h0);
    nxt(); smp();
    chk("rst_fetch.mem_addr", mem_addr, 32'h700);
    chk("rst_fetch.if_ready", 32'(if_ready), 32'h1);
    chk("rst_fetch.if_rdata", if_rdata, 32'h0000_ABCD);
    nxt(); if_req = 0; mem_ready = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles one memory access may wait for mem_ready before it is aborted.
REQ-002 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: if_req  in  1  instruction fetch request; held until the if_ready pulse.
REQ-005 Port: if_addr  in  32  fetch address; stable while if_req is high.
REQ-006 Port: if_flush  in  1  kills the in-flight or same-cycle fetch (jal/jalr/branch redirect).
REQ-007 Port: if_ready  out  1  one-cycle fetch-completion pulse.
REQ-008 Port: if_rdata  out  32  fetched instruction; valid only while if_ready is high, 0 otherwise.
REQ-009 Port: d_req, d_we  in  1 each  data request, write enable.
REQ-010 Port: d_addr, d_wdata  in  32 each  data address, write data.
REQ-011 Port: d_be  in  4  byte enables.
REQ-012 Port: d_ready  out  1  one-cycle data-completion pulse.
REQ-013 Port: d_rdata  out  32  load data; valid only while d_ready is high, 0 otherwise.
REQ-014 Port: mem_req, mem_we  out  1 each  memory request, write enable.
REQ-015 Port: mem_addr, mem_wdata  out  32 each  memory address, write data.
REQ-016 Port: mem_be  out  4  memory byte enables.
REQ-017 Port: mem_rdata  in  32  memory read data.
REQ-018 Port: mem_ready  in  1  memory completion; sampled only while mem_req is high.
REQ-019 Port: bus_err  out  1  one-cycle timeout pulse.
REQ-020 Port: err_addr  out  32  address of the most recent timed-out access.

Function
REQ-021 FSM states SHALL be: IDLE, IF_BUSY, D_BUSY.
REQ-022 IDLE with exactly one valid request SHALL grant it on the next edge; a fetch request is valid only when if_req=1 and if_flush=0.
REQ-023 IDLE with both requests valid SHALL grant the requester not granted last; last_grant SHALL reset to IF, so the first tie goes to data.
REQ-024 On grant, address, wdata, be and we SHALL be latched into internal registers; a fetch SHALL latch we=0 and be=4'hF.
REQ-025 mem_req SHALL be 1 exactly while state is IF_BUSY or D_BUSY; mem_addr, mem_wdata, mem_be and mem_we SHALL come from the latched registers, and SHALL be 0 in IDLE.
REQ-026 mem_ready=1 in a BUSY state SHALL pulse the matching x_ready in that same cycle with x_rdata=mem_rdata, and the FSM SHALL return to IDLE on the next edge.
REQ-027 Minimum latency SHALL be: request at cycle N, mem_req at N+1, x_ready at N+1 if memory answers at once; back-to-back accesses SHALL have one IDLE cycle between them.
REQ-028 A wait counter SHALL clear on grant and increment each BUSY cycle without mem_ready.
REQ-029 When the wait counter reaches TIMEOUT, the access SHALL be aborted: x_ready pulses, if_rdata=32'h00000013 (NOP) or d_rdata=0, bus_err pulses, err_addr takes the latched address, and the FSM goes to IDLE.
REQ-030 mem_ready and timeout in the same cycle SHALL be treated as a normal completion, with no bus_err.
REQ-031 if_flush=1 during IF_BUSY SHALL set a kill flag; the memory access still completes, but if_ready stays 0 for it.
REQ-032 The kill flag SHALL clear on the return to IDLE.
REQ-033 if_flush SHALL have no effect on D_BUSY or on data requests.
REQ-034 A write with d_be=4'h0 SHALL be issued normally.
REQ-035 Requests arriving while BUSY SHALL wait; nothing is queued beyond the held req lines.

Reset
REQ-036 rst=1 at an edge SHALL force: state IDLE, last_grant IF, wait counter 0, kill flag 0, err_addr 0.
REQ-037 While in reset, all outputs SHALL be 0.
REQ-038 Reset during BUSY SHALL drop mem_req after that edge, and no x_ready SHALL be produced for the abandoned access.

Verification
REQ-039 Fetch: if_req=1, if_addr=0x100; mem answers next cycle with 0x00500093 -> mem_req/mem_addr=0x100 at N+1, if_ready=1 with if_rdata=0x00500093 at N+1.
REQ-040 Tie: if_req and d_req (load, d_addr=0x2000) both high from reset -> data served first, then one IDLE cycle, then fetch; on the next tie, fetch wins.
REQ-041 Store: d_we=1, d_be=4'h3, d_addr=0x2004, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=4'h3, mem_wdata=0xDEADBEEF; d_ready pulses once.
REQ-042 Flush: fetch at 0x200, if_flush=1 one cycle later, mem_ready 3 cycles later -> no if_ready, FSM back in IDLE, next fetch at 0x300 served normally.
REQ-043 Timeout with TIMEOUT=4 and mem_ready held at 0 on a load at 0x3000 -> after 4 BUSY cycles: d_ready=1, d_rdata=0, bus_err=1, err_addr=0x3000.
REQ-044 Reset asserted in D_BUSY -> next cycle mem_req=0, all outputs 0, and a following fetch is served normally.
